// File: rtl/dual_port_ram.sv
// Simple-dual-port RAM with one write port and one read port on a single clock.
// It provides byte-lane write enables, a read latency of 1 or 2 cycles, a
// selectable read-during-write result, and dropping plus flagging of
// out-of-range accesses. When CLEAR_ON_RESET is set, it zeroes every word
// after reset and ignores requests while that clear runs.
module dual_port_ram #(
  parameter int ADDR_WIDTH     = 4,
  parameter int MEMORY_DEPTH   = 16,
  parameter int MEM_WIDTH      = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             WrEn,
  input  logic [ADDR_WIDTH-1:0]            WrAddress,
  input  logic [MEM_WIDTH-1:0]             WrData,
  input  logic [MEM_WIDTH/BYTE_WIDTH-1:0]  WrByteEn,
  input  logic                             RdEn,
  input  logic [ADDR_WIDTH-1:0]            RdAddress,
  output logic [MEM_WIDTH-1:0]             RdData,
  output logic                             RdValid,
  output logic                             Busy,
  output logic                             AddrErr
);

  localparam int NUM_BYTES = MEM_WIDTH / BYTE_WIDTH;
  localparam int IDX_W     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(MEMORY_DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } stateT;

  stateT                state;
  logic [IDX_W-1:0]     clrIdx;
  logic [MEM_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic                 wrInRange;
  logic                 rdInRange;
  logic [IDX_W-1:0]     wrIdx;
  logic [IDX_W-1:0]     rdIdx;
  logic                 wrAccept;
  logic                 rdAccept;
  logic                 errNow;
  logic [MEM_WIDTH-1:0] rdWord;

  logic                 p1Valid;
  logic [MEM_WIDTH-1:0] p1Data;
  logic                 p2Valid;
  logic [MEM_WIDTH-1:0] p2Data;

  // The address is compared with one extra bit so that an address at or past the depth is never folded onto a real word.
  assign wrInRange = {1'b0, WrAddress} < DEPTH_LIMIT;
  assign rdInRange = {1'b0, RdAddress} < DEPTH_LIMIT;
  assign wrIdx     = WrAddress[IDX_W-1:0];
  assign rdIdx     = RdAddress[IDX_W-1:0];

  // Requests count only in READY and outside reset. An out-of-range read is still accepted and returns zero.
  assign wrAccept = (state == READY) && !Rst && WrEn && wrInRange;
  assign rdAccept = (state == READY) && !Rst && RdEn;
  assign errNow   = (state == READY) && !Rst &&
                    ((WrEn && !wrInRange) || (RdEn && !rdInRange));

  // Read word selection: zero when the address is out of range. In merged mode, lanes being written this cycle are replaced by the new data.
  always_comb begin
    rdWord = '0;
    if (rdInRange) begin
      rdWord = mem[rdIdx];
      if ((RDW_MODE == 1) && wrAccept && (wrIdx == rdIdx)) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (WrByteEn[b]) begin
            rdWord[b*BYTE_WIDTH +: BYTE_WIDTH] = WrData[b*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Control FSM: a clear sweep after reset, then steady READY. Busy is registered together with the state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      clrIdx <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state <= CLEAR;
        Busy  <= 1'b1;
      end else begin
        state <= READY;
        Busy  <= 1'b0;
      end
    end else begin
      case (state)
        CLEAR: begin
          if (clrIdx == LAST_IDX) begin
            state  <= READY;
            Busy   <= 1'b0;
            clrIdx <= '0;
          end else begin
            clrIdx <= clrIdx + 1'b1;
          end
        end
        READY: begin
          Busy <= 1'b0;
        end
        default: begin
          state <= READY;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: the clear sweep writes one zero word per cycle. Otherwise an accepted write updates only its enabled byte lanes.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == CLEAR) begin
        mem[clrIdx] <= '0;
      end else if (wrAccept) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (WrByteEn[b]) begin
            mem[wrIdx][b*BYTE_WIDTH +: BYTE_WIDTH] <= WrData[b*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Read pipeline: data registers load only with a valid read, so the output holds between reads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      p1Valid <= 1'b0;
      p1Data  <= '0;
      p2Valid <= 1'b0;
      p2Data  <= '0;
    end else begin
      p1Valid <= rdAccept;
      if (rdAccept) begin
        p1Data <= rdWord;
      end
      p2Valid <= p1Valid;
      if (p1Valid) begin
        p2Data <= p1Data;
      end
    end
  end

  // Error flag: one pulse per offending cycle, whichever port or ports caused it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      AddrErr <= 1'b0;
    end else begin
      AddrErr <= errNow;
    end
  end

  assign RdData  = (RD_LATENCY == 2) ? p2Data  : p1Data;
  assign RdValid = (RD_LATENCY == 2) ? p2Valid : p1Valid;

endmodule
